qspi_flash_rsp: RTL and testbench

QSPI_FLASH_RSP -- requirements
Module: qspi_flash_rsp

---
 rtl/qspi_flash_rsp.sv | 228 ++++++++++++++++++++++
 tb/tb_qspi_flash_rsp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_rsp.sv
// QSPI flash read responder: serves 0x03 (single read) and 0x6B (quad output read)
// from a byte-wide backing memory, with one byte of prefetch ahead of the shifter.
module qspi_flash_rsp #(
  parameter int unsigned AddrWidth  = 24,
  parameter int unsigned SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flash_sck_i,
  input  logic                 flash_ce_n_i,
  input  logic [3:0]           flash_din_i,
  output logic [3:0]           flash_dout_o,
  output logic [3:0]           flash_dout_en_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [7:0]           mem_rdata_i,
  output logic                 busy_o,
  output logic                 cmd_err_o
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StData, StIgnore
  } state_e;

  logic [SyncStages-1:0]      sck_sync_q, sck_sync_d, ce_sync_q, ce_sync_d;
  logic [SyncStages-1:0][3:0] din_sync_q, din_sync_d;
  logic                       sck_prev_q, ce_prev_q;
  logic                       sck_s, ce_s;
  logic [3:0]                 din_s;
  logic                       sck_rise, sck_fall, ce_rise, ce_fall;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [22:0]            sr_q, sr_d;
  logic                   quad_q, quad_d;
  logic [7:0]             tx_q, tx_d;
  logic [2:0]             tx_cnt_q, tx_cnt_d;
  logic [7:0]             buf_q, buf_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [3:0]             dout_q, dout_d;
  logic                   mem_req_q, mem_req_d;
  logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
  logic                   cmd_err_q, cmd_err_d;
  logic [23:0]            addr_full;
  logic [7:0]             opcode;
  logic                   unused_ok;

  always_comb begin
    sck_sync_d[0] = flash_sck_i;
    ce_sync_d[0]  = flash_ce_n_i;
    din_sync_d[0] = flash_din_i;
    for (int unsigned i = 1; i < SyncStages; i++) begin
      sck_sync_d[i] = sck_sync_q[i-1];
      ce_sync_d[i]  = ce_sync_q[i-1];
      din_sync_d[i] = din_sync_q[i-1];
    end
  end

  assign sck_s     = sck_sync_q[SyncStages-1];
  assign ce_s      = ce_sync_q[SyncStages-1];
  assign din_s     = din_sync_q[SyncStages-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign ce_rise   = ce_s & ~ce_prev_q;
  assign ce_fall   = ~ce_s & ce_prev_q;
  assign addr_full = {sr_q, din_s[0]};
  assign opcode    = {sr_q[6:0], din_s[0]};
  assign unused_ok = ^{din_s[3:1], addr_full};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    quad_d     = quad_q;
    tx_d       = tx_q;
    tx_cnt_d   = tx_cnt_q;
    buf_d      = buf_q;
    dout_d     = dout_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = 1'b0;
    cmd_err_d  = 1'b0;
    // Read data returns one cycle after the request; it always lands in the prefetch byte.
    rd_pend_d  = mem_req_q;
    if (rd_pend_q) buf_d = mem_rdata_i;

    unique case (state_q)
      StIdle: begin
        if (ce_fall) begin
          state_d = StCmd;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      StCmd: begin
        if (sck_rise) begin
          sr_d  = {sr_q[21:0], din_s[0]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            unique case (opcode)
              8'h03: begin quad_d = 1'b0; state_d = StAddr; end
              8'h6B: begin quad_d = 1'b1; state_d = StAddr; end
              default: begin state_d = StIgnore; cmd_err_d = 1'b1; end
            endcase
          end
        end
      end
      StAddr: begin
        if (sck_rise) begin
          sr_d  = {sr_q[21:0], din_s[0]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d      = '0;
            tx_cnt_d   = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_full[AddrWidth-1:0];
            state_d    = quad_q ? StDummy : StData;
          end
        end
      end
      StDummy: begin
        if (sck_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (sck_fall) begin
          if (tx_cnt_q == 3'd0) begin
            // Shifter empty: take the prefetched byte and fetch the one after it.
            if (quad_q) begin
              dout_d   = buf_q[7:4];
              tx_d     = {buf_q[3:0], 4'b0000};
              tx_cnt_d = 3'd1;
            end else begin
              dout_d   = {2'b00, buf_q[7], 1'b0};
              tx_d     = {buf_q[6:0], 1'b0};
              tx_cnt_d = 3'd7;
            end
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q + AddrWidth'(1);
          end else begin
            if (quad_q) begin
              dout_d = tx_q[7:4];
              tx_d   = {tx_q[3:0], 4'b0000};
            end else begin
              dout_d = {2'b00, tx_q[7], 1'b0};
              tx_d   = {tx_q[6:0], 1'b0};
            end
            tx_cnt_d = tx_cnt_q - 3'd1;
          end
        end
      end
      StIgnore: ;
      default: state_d = StIdle;
    endcase

    if (ce_rise) begin
      state_d   = StIdle;
      cnt_d     = '0;
      sr_d      = '0;
      quad_d    = 1'b0;
      tx_d      = '0;
      tx_cnt_d  = '0;
      buf_d     = '0;
      rd_pend_d = 1'b0;
      dout_d    = '0;
      mem_req_d = 1'b0;
      cmd_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q <= '0;
      ce_sync_q  <= '1;
      din_sync_q <= '0;
      sck_prev_q <= 1'b0;
      ce_prev_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      sr_q       <= '0;
      quad_q     <= 1'b0;
      tx_q       <= '0;
      tx_cnt_q   <= '0;
      buf_q      <= '0;
      rd_pend_q  <= 1'b0;
      dout_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ce_sync_q  <= ce_sync_d;
      din_sync_q <= din_sync_d;
      sck_prev_q <= sck_s;
      ce_prev_q  <= ce_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      quad_q     <= quad_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      buf_q      <= buf_d;
      rd_pend_q  <= rd_pend_d;
      dout_q     <= dout_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Enables decode straight from the async-reset state flop so reset drops drive at once.
  always_comb begin
    flash_dout_en_o = 4'b0000;
    if (state_q == StData) flash_dout_en_o = quad_q ? 4'b1111 : 4'b0010;
  end

  assign flash_dout_o = dout_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign busy_o       = (state_q != StIdle);
  assign cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_rsp.sv
// Directed bench for qspi_flash_rsp: a 24-bit and an 8-bit address instance share the bus.
module tb_qspi_flash_rsp;
  localparam int unsigned SYNC = 2;
  localparam int unsigned H    = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        ce_n = 1'b1;
  logic [3:0]  din = 4'h0;

  logic [3:0]  dout24, en24, dout8, en8;
  logic        req24, busy24, err24, req8, busy8, err8;
  logic [23:0] addr24;
  logic [7:0]  addr8;
  logic [7:0]  rdata24 = 8'h00, rdata8 = 8'h00;

  logic [7:0]  mem [256];
  logic [23:0] q24 [$];
  logic [7:0]  q8 [$];
  int          err_cycles = 0;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  qspi_flash_rsp #(.AddrWidth(24), .SyncStages(SYNC)) u_dut24 (
    .clk_i(clk), .rst_ni(rst_n), .flash_sck_i(sck), .flash_ce_n_i(ce_n),
    .flash_din_i(din), .flash_dout_o(dout24), .flash_dout_en_o(en24),
    .mem_req_o(req24), .mem_addr_o(addr24), .mem_rdata_i(rdata24),
    .busy_o(busy24), .cmd_err_o(err24));

  qspi_flash_rsp #(.AddrWidth(8), .SyncStages(SYNC)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .flash_sck_i(sck), .flash_ce_n_i(ce_n),
    .flash_din_i(din), .flash_dout_o(dout8), .flash_dout_en_o(en8),
    .mem_req_o(req8), .mem_addr_o(addr8), .mem_rdata_i(rdata8),
    .busy_o(busy8), .cmd_err_o(err8));

  always @(posedge clk) begin
    rdata24 <= mem[addr24[7:0]];
    rdata8  <= mem[addr8];
    if (req24) q24.push_back(addr24);
    if (req8) q8.push_back(addr8);
    if (err24) err_cycles = err_cycles + 1;
  end

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int unsigned n;
    logic        quad;
    logic [15:0] exp_data;
    int unsigned exp_reqs;
    int unsigned exp_err;
    logic [3:0]  exp_en;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_h();
    repeat (H) @(posedge clk);
    #2;
  endtask

  task automatic clk_bit(input logic [3:0] d, output logic [3:0] se);
    din = d;
    wait_h();
    se = en24;
    sck = 1'b1;
    wait_h();
    sck = 1'b0;
  endtask

  task automatic start(input logic [7:0] op, input logic [23:0] a, output logic [3:0] en_or);
    logic [3:0] se;
    q24.delete();
    q8.delete();
    err_cycles = 0;
    en_or = 4'h0;
    ce_n = 1'b0;
    wait_h();
    for (int i = 7; i >= 0; i--) begin clk_bit({3'b000, op[i]}, se); en_or |= se; end
    if (op == 8'h03 || op == 8'h6B) begin
      for (int i = 23; i >= 0; i--) begin clk_bit({3'b000, a[i]}, se); en_or |= se; end
      if (op == 8'h6B)
        for (int i = 0; i < 8; i++) begin clk_bit(4'h0, se); en_or |= se; end
    end else begin
      for (int i = 0; i < 8; i++) begin clk_bit(4'h0, se); en_or |= se; end
    end
  endtask

  task automatic data_clk(input bit last, output logic [3:0] so, output logic [3:0] se,
                          output logic ba, output logic [3:0] ea);
    din = 4'h0;
    wait_h();
    so = dout24;
    se = en24;
    sck = 1'b1;
    wait_h();
    ba = busy24;
    ea = en24;
    if (last) begin
      ce_n = 1'b1;
      repeat (SYNC + 1) @(posedge clk);
      #2;
      ba = busy24;
      ea = en24;
    end
    sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] op, input logic [23:0] a, input int unsigned n,
                      input logic quad, output logic [15:0] data, output logic [3:0] en_first,
                      output logic [3:0] en_pre, output logic ba, output logic [3:0] ea);
    logic [3:0] so, se;
    start(op, a, en_pre);
    data = 16'h0000;
    en_first = 4'h0;
    for (int unsigned i = 0; i < n; i++) begin
      data_clk(i == n - 1, so, se, ba, ea);
      data = quad ? {data[11:0], so} : {data[14:0], so[1]};
      if (i == 0) en_first = se;
    end
    if (n == 0) begin
      ce_n = 1'b1;
      repeat (SYNC + 1) @(posedge clk);
      #2;
      ba = busy24;
      ea = en24;
    end
    wait_h();
  endtask

  logic [15:0] data;
  logic [3:0]  en_first, en_pre, ea, so, se;
  logic        ba;
  logic [31:0] g0, g1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h20] = 8'h5A;
    mem[8'hFF] = 8'h77; mem[8'h00] = 8'hC3;

    vecs[0] = '{8'h03, 24'h000010, 16, 1'b0, 16'hA53C, 3, 0, 4'h2};
    vecs[1] = '{8'h6B, 24'h000020,  2, 1'b1, 16'h005A, 2, 0, 4'hF};
    vecs[2] = '{8'h9F, 24'h000000,  0, 1'b0, 16'h0000, 0, 1, 4'h0};
    vecs[3] = '{8'h03, 24'h0000FF, 16, 1'b0, 16'h77C3, 3, 0, 4'h2};
    vecs[4] = '{8'h6B, 24'h000010,  4, 1'b1, 16'hA53C, 3, 0, 4'hF};
    vecs[5] = '{8'h03, 24'h000011,  8, 1'b0, 16'h003C, 2, 0, 4'h2};

    repeat (3) @(posedge clk);
    #2;
    check("reset outputs in reset", {dout24, en24, req24, busy24, err24, addr24}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("reset outputs after release", {dout24, en24, req24, busy24, err24, addr24}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].op, vecs[i].addr, vecs[i].n, vecs[i].quad, data, en_first, en_pre, ba, ea);
      if (vecs[i].n > 0) begin
        check($sformatf("v%0d data", i), {16'h0, data}, {16'h0, vecs[i].exp_data});
        check($sformatf("v%0d en in data", i), {28'h0, en_first}, {28'h0, vecs[i].exp_en});
      end
      check($sformatf("v%0d en before data", i), {28'h0, en_pre}, 32'h0);
      check($sformatf("v%0d req count", i), q24.size(), vecs[i].exp_reqs);
      check($sformatf("v%0d err cycles", i), err_cycles, vecs[i].exp_err);
      check($sformatf("v%0d busy after ce", i), {31'h0, ba}, 32'h0);
      check($sformatf("v%0d en after ce", i), {28'h0, ea}, 32'h0);
      if (vecs[i].exp_reqs > 1) begin
        g0 = (q24.size() > 0) ? {8'h0, q24[0]} : 32'hFFFF_FFFF;
        g1 = (q24.size() > 1) ? {8'h0, q24[1]} : 32'hFFFF_FFFF;
        check($sformatf("v%0d addr0", i), g0, {8'h0, vecs[i].addr});
        check($sformatf("v%0d addr1", i), g1, {8'h0, vecs[i].addr + 24'd1});
        g0 = (q8.size() > 0) ? {24'h0, q8[0]} : 32'hFFFF_FFFF;
        g1 = (q8.size() > 1) ? {24'h0, q8[1]} : 32'hFFFF_FFFF;
        check($sformatf("v%0d aw8 addr0", i), g0, {24'h0, vecs[i].addr[7:0]});
        check($sformatf("v%0d aw8 addr1", i), g1, {24'h0, vecs[i].addr[7:0] + 8'd1});
      end
    end

    // Width-8 wrap on the 0xFF read, written out explicitly.
    xfer(8'h03, 24'h0000FF, 16, 1'b0, data, en_first, en_pre, ba, ea);
    g0 = (q8.size() > 1) ? {16'h0, q8[0], q8[1]} : 32'hFFFF_FFFF;
    check("aw8 wrap sequence", g0, 32'h0000_FF00);

    // Abort after three data bits, then a clean read from address 0.
    xfer(8'h03, 24'h000000, 3, 1'b0, data, en_first, en_pre, ba, ea);
    check("abort bits", {29'h0, data[2:0]}, 32'h6);
    check("abort busy", {31'h0, ba}, 32'h0);
    check("abort en", {28'h0, ea}, 32'h0);
    xfer(8'h03, 24'h000000, 8, 1'b0, data, en_first, en_pre, ba, ea);
    check("read after abort", {16'h0, data}, 32'h0000_00C3);

    // Reset in the middle of a quad data phase.
    start(8'h6B, 24'h000020, en_pre);
    data_clk(1'b0, so, se, ba, ea);
    check("quad hi nibble before reset", {28'h0, so}, 32'h5);
    wait_h();
    check("quad en before reset", {28'h0, en24}, 32'hF);
    #4 rst_n = 1'b0;
    #1;
    check("en on reset", {28'h0, en24}, 32'h0);
    check("dout on reset", {28'h0, dout24}, 32'h0);
    ce_n = 1'b1;
    sck = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("outputs after reset release", {dout24, en24, req24, busy24, err24, addr24}, 32'h0);
    check("aw8 outputs after reset release", {16'h0, dout8, en8, req8, busy8, err8, addr8}, 32'h0);

    xfer(8'h03, 24'h000010, 8, 1'b0, data, en_first, en_pre, ba, ea);
    check("read after reset", {16'h0, data}, 32'h0000_00A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
